// File: rtl/timer_irq_unit.sv
// Memory-mapped interval timer with prescaler, auto-reload and sticky
// interrupt status; IRQ is masked while the CPU runs in kernel mode.
module timer_irq_unit #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int unsigned PSC_WIDTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        kernel,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [31:0] rdata,
   output logic        hit,
   output logic        IRQ
);

   logic [31:0]          th;
   logic [31:0]          tl;
   logic [2:0]           tcon;
   logic [PSC_WIDTH-1:0] psc;
   logic [PSC_WIDTH-1:0] pcnt;

   logic en;
   logic ie;
   logic st;
   logic wr;
   logic wr_th;
   logic wr_tl;
   logic wr_tcon;
   logic wr_psc;
   logic tick;
   logic ovf;
   logic unused_lsb;

   assign en = tcon[0];
   assign ie = tcon[1];
   assign st = tcon[2];

   // byte lane bits play no part in decoding
   assign unused_lsb = ^addr[1:0];

   assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
   assign wr      = MemWrite & hit;
   assign wr_th   = wr & (addr[3:2] == 2'd0);
   assign wr_tl   = wr & (addr[3:2] == 2'd1);
   assign wr_tcon = wr & (addr[3:2] == 2'd2);
   assign wr_psc  = wr & (addr[3:2] == 2'd3);

   assign tick = en & (pcnt == psc);
   assign ovf  = tick & (tl == 32'hFFFF_FFFF);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         psc  <= '0;
         pcnt <= '0;
      end else if (wr_psc) begin
         psc  <= wdata[PSC_WIDTH-1:0];
         pcnt <= '0;
      end else if (tick) begin
         pcnt <= '0;
      end else if (en) begin
         pcnt <= pcnt + PSC_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th <= '0;
      end else if (wr_th) begin
         th <= wdata;
      end
   end

   // reload takes the pre-edge TH even if TH is written on this edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tl <= '0;
      end else if (wr_tl) begin
         tl <= wdata;
      end else if (ovf) begin
         tl <= th;
      end else if (tick) begin
         tl <= tl + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tcon <= '0;
      end else if (wr_tcon) begin
         tcon <= wdata[2:0];
      end else if (ovf & ie) begin
         tcon[2] <= 1'b1;
      end
   end

   assign IRQ = ie & st & ~kernel;

   always_comb begin
      rdata = '0;
      if (MemRead & hit) begin
         unique case (addr[3:2])
            2'd0: rdata = th;
            2'd1: rdata = tl;
            2'd2: rdata = {29'b0, tcon};
            2'd3: rdata = 32'(psc);
         endcase
      end
   end

endmodule

// File: tb/tb_timer_irq_unit.sv
// Randomized and directed bench for timer_irq_unit against a
// behavioural model of the timer registers.
module tb_timer_irq_unit;

   localparam logic [31:0] BASE   = 32'h4000_0000;
   localparam logic [31:0] A_TH   = BASE;
   localparam logic [31:0] A_TL   = BASE + 32'd4;
   localparam logic [31:0] A_TCON = BASE + 32'd8;
   localparam logic [31:0] A_PSC  = BASE + 32'd12;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        kernel = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] rdata;
   logic        hit;
   logic        IRQ;

   int n_cmp = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #10 clk = ~clk;

   timer_irq_unit #(
      .BASE_ADDR(BASE),
      .PSC_WIDTH(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .kernel(kernel),
      .addr(addr),
      .wdata(wdata),
      .MemRead(MemRead),
      .MemWrite(MemWrite),
      .rdata(rdata),
      .hit(hit),
      .IRQ(IRQ)
   );

   logic [31:0] m_th = '0;
   logic [31:0] m_tl = '0;
   logic [31:0] old_th;
   bit          m_en = 0;
   bit          m_ie = 0;
   bit          m_st = 0;
   int unsigned m_psc = 0;
   int unsigned m_since = 0;
   bit          ms_wr;
   bit          ms_fire;
   bit          ms_wrap;

   function automatic bit in_win(logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'd16);
   endfunction

   function automatic logic [31:0] m_rd(logic [31:0] a);
      logic [31:0] off;
      off = (a - BASE) >> 2;
      case (off)
         0: return m_th;
         1: return m_tl;
         2: return {29'b0, m_st, m_ie, m_en};
         default: return m_psc;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // a tick comes after m_psc+1 enabled cycles; writes override tick effects
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_th = '0; m_tl = '0; m_en = 0; m_ie = 0; m_st = 0;
         m_psc = 0; m_since = 0;
      end else begin
         ms_wr   = MemWrite && in_win(addr);
         ms_fire = m_en && (m_since == m_psc);
         ms_wrap = ms_fire && (m_tl == 32'hFFFF_FFFF);
         old_th  = m_th;
         if (ms_fire) m_since = 0;
         else if (m_en) m_since = m_since + 1;
         if (ms_fire) m_tl = ms_wrap ? old_th : m_tl + 32'd1;
         if (ms_wrap && m_ie) m_st = 1;
         if (ms_wr) begin
            case ((addr - BASE) >> 2)
               0: m_th = wdata;
               1: m_tl = wdata;
               2: {m_st, m_ie, m_en} = wdata[2:0];
               default: begin
                  m_psc = {16'b0, wdata[15:0]};
                  m_since = 0;
               end
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("hit", {31'b0, hit}, {31'b0, in_win(addr)});
         chk("rdata", rdata,
             (MemRead && in_win(addr)) ? m_rd(addr) : 32'd0);
         chk("irq", {31'b0, IRQ}, {31'b0, m_ie & m_st & ~kernel});
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a;
      wdata = d;
      MemRead = 1'b0;
      MemWrite = 1'b1;
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
   endtask

   task automatic peek(input logic [31:0] a, input logic [31:0] exp,
                       input string nm);
      addr = a;
      MemRead = 1'b1;
      #1;
      chk(nm, rdata, exp);
      MemRead = 1'b0;
   endtask

   task automatic irq_is(input bit e, input string nm);
      chk(nm, {31'b0, IRQ}, {31'b0, e});
   endtask

   initial begin
      int r;
      int k;
      logic [31:0] a;
      logic [31:0] d;

      #2 reset = 1'b0;
      #30 reset = 1'b1;
      step(1);
      chk_en = 1'b1;

      // reset mid-count
      wr(A_TH, 32'h100);
      wr(A_TL, 32'hFFFF_FFF0);
      wr(A_TCON, 32'd3);
      step(20);
      peek(A_TL, 32'h104, "pre_rst_tl");
      irq_is(1'b1, "pre_rst_irq");
      reset = 1'b0;
      #1 irq_is(1'b0, "rst_irq");
      @(posedge clk);
      #3 reset = 1'b1;
      peek(A_TH, 32'd0, "rst_th");
      peek(A_TL, 32'd0, "rst_tl");
      peek(A_TCON, 32'd0, "rst_tcon");
      peek(A_PSC, 32'd0, "rst_psc");
      peek(BASE + 32'd16, 32'd0, "out_rdata");
      chk("out_hit", {31'b0, hit}, 32'd0);

      // basic overflow
      step(1);
      wr(A_TCON, 32'd0);
      wr(A_TH, 32'hFFFF_FFFC);
      wr(A_TL, 32'hFFFF_FFFE);
      wr(A_PSC, 32'd0);
      wr(A_TCON, 32'd3);
      peek(A_TL, 32'hFFFF_FFFE, "ovf_tl0");
      step(1);
      peek(A_TL, 32'hFFFF_FFFF, "ovf_tl1");
      irq_is(1'b0, "ovf_irq1");
      step(1);
      peek(A_TL, 32'hFFFF_FFFC, "ovf_tl2");
      peek(A_TCON, 32'd7, "ovf_tcon");
      irq_is(1'b1, "ovf_irq2");

      // kernel masking and clear
      kernel = 1'b1;
      #1 irq_is(1'b0, "kern_mask");
      wr(A_TCON, 32'd3);
      peek(A_TCON, 32'd3, "st_clear");
      kernel = 1'b0;
      #1 irq_is(1'b0, "kern_off_irq");

      // prescaler
      wr(A_TCON, 32'd0);
      wr(A_PSC, 32'd3);
      wr(A_TL, 32'd0);
      wr(A_TCON, 32'd1);
      step(4);
      peek(A_TL, 32'd1, "psc_t4");
      step(4);
      peek(A_TL, 32'd2, "psc_t8");
      wr(A_TCON, 32'd0);
      wr(A_PSC, 32'd3);
      wr(A_TL, 32'd0);
      wr(A_TCON, 32'd1);
      step(4);
      peek(A_TL, 32'd1, "frz_t4");
      step(1);
      wr(A_TCON, 32'd0);
      step(3);
      peek(A_TL, 32'd1, "frz_t9");
      wr(A_TCON, 32'd1);
      step(1);
      peek(A_TL, 32'd1, "frz_t11");
      step(1);
      peek(A_TL, 32'd2, "frz_t12");

      // IE off
      wr(A_TCON, 32'd0);
      wr(A_TH, 32'h10);
      wr(A_TL, 32'hFFFF_FFFF);
      wr(A_PSC, 32'd0);
      wr(A_TCON, 32'd1);
      step(1);
      peek(A_TL, 32'h10, "ieoff_tl");
      peek(A_TCON, 32'd1, "ieoff_tcon");
      irq_is(1'b0, "ieoff_irq");

      // collisions
      wr(A_TCON, 32'd0);
      wr(A_TL, 32'd9);
      wr(A_TCON, 32'd1);
      wr(A_TL, 32'd5);
      peek(A_TL + 32'd3, 32'd5, "col_tl");
      wr(A_TCON, 32'd0);
      wr(A_TH, 32'd2);
      wr(A_TL, 32'hFFFF_FFFF);
      wr(A_TCON, 32'd3);
      wr(A_TH, 32'd7);
      peek(A_TL, 32'd2, "col_th_tl");
      peek(A_TH, 32'd7, "col_th_th");
      peek(A_TCON, 32'd7, "col_th_st");
      wr(A_TCON, 32'd0);
      wr(A_TL, 32'hFFFF_FFFF);
      wr(A_TCON, 32'd3);
      wr(A_TCON, 32'hFFFF_FFFB);
      peek(A_TCON, 32'd3, "col_tcon");

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         kernel = 1'($urandom_range(0, 1));
         MemRead = 1'($urandom_range(0, 1));
         MemWrite = 1'b0;
         r = $urandom_range(0, 9);
         k = $urandom_range(0, 3);
         if (r < 8) a = BASE + 32'(k * 4) + 32'($urandom_range(0, 3));
         else if (r == 8) a = BASE + 32'd16 + 32'($urandom_range(0, 64));
         else a = $urandom;
         case (k)
            0: d = ($urandom_range(0, 1) == 1) ? $urandom
                                               : 32'hFFFF_FFF0 + 32'($urandom_range(0, 8));
            1: begin
               r = $urandom_range(0, 2);
               d = (r == 0) ? 32'hFFFF_FFFF
                 : (r == 1) ? 32'hFFFF_FFFD : $urandom;
            end
            2: begin
               d = $urandom;
               d[0] = ($urandom_range(0, 3) != 0);
            end
            default: d = 32'($urandom_range(0, 3));
         endcase
         addr = a;
         wdata = d;
         if ($urandom_range(0, 99) < 20) MemWrite = 1'b1;
         if ($urandom_range(0, 299) == 0) begin
            #2 reset = 1'b0;
            #2 reset = 1'b1;
         end
         step(1);
      end

      MemRead = 1'b0;
      MemWrite = 1'b0;
      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_irq_unit.md
Name: timer_irq_unit

Overview:
Memory-mapped interval timer that generates the IRQ input consumed by the single-cycle control unit. It sits on the data-memory bus beside data RAM and is decoded by address. It counts with a programmable prescaler, reloads on overflow, and latches an interrupt status bit. IRQ is raised only when the CPU is in user mode (PC[31]=0), which keeps the handler from re-entering itself.

Parameters:
BASE_ADDR, 32'h4000_0000, byte address of the TH register; TL is at +4, TCON at +8, PSC at +12.
PSC_WIDTH, 16, width of the prescaler reload register and its counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
kernel  input  1  PC[31] of the current instruction; 1 means kernel mode.
addr  input  32  data-bus byte address.
wdata  input  32  data-bus write data.
MemRead  input  1  bus read strobe.
MemWrite  input  1  bus write strobe; the write commits on the clock edge.
rdata  output  32  combinational read data; 0 when not selected.
hit  output  1  addr falls in BASE_ADDR..BASE_ADDR+15 (word-aligned); the bus mux uses it to select rdata.
IRQ  output  1  interrupt request to the control unit.

Behaviour:
- Registers: TH[31:0] (reload value), TL[31:0] (count), TCON[2:0], PSC[PSC_WIDTH-1:0] (prescale reload), plus an internal prescaler counter pcnt.
- TCON bit 0 is EN (count enable), bit 1 is IE (interrupt enable), bit 2 is ST (status, sticky).
- Reset (reset=0, async): TH=0, TL=0, TCON=0, PSC=0, pcnt=0, IRQ=0. rdata is 0 unless selected.
- Tick generation while EN=1:
  - When pcnt==PSC, a tick fires and pcnt resets to 0.
  - Otherwise pcnt increments.
  - With PSC=0 there is one tick every cycle.
  - When EN=0, pcnt holds.
- On a tick:
  - If TL==32'hFFFF_FFFF, TL loads TH (overflow) and ST is set if IE=1.
  - Otherwise TL increments by 1 (modulo 2^32).
- ST is sticky. It clears only by a bus write to TCON with wdata[2]=0, or by reset.
- IRQ = IE & ST & ~kernel, purely combinational. It drops in the same cycle kernel rises.
- Bus writes (MemWrite=1 and hit=1, decoded on addr[3:2]):
  - 00 writes TH.
  - 01 writes TL.
  - 10 writes TCON[2:0]; wdata[31:3] are ignored.
  - 11 writes PSC and resets pcnt to 0.
- Reads (MemRead=1 and hit=1):
  - rdata returns the register, zero-extended (TCON returns {29'b0, TCON}).
  - A read in the same cycle as a write returns the pre-edge value.
  - There are no read side effects.
- Address rules: addr[1:0] are ignored. Addresses outside the window give hit=0, no write, and rdata=0.
- Simultaneous events:
  - A bus write to TL in the same cycle as a tick means the write wins and the tick increment is discarded.
  - A bus write to TCON in the same cycle as an overflow means the written value wins. Software therefore loses a set that coincides with its own clear, and this is accepted.
  - A bus write to TH in the same cycle as an overflow means TL reloads the OLD TH and TH takes the new value.
  - Clearing EN mid-prescale freezes pcnt. Re-enabling resumes from the frozen value.
- Reset mid-count: all state returns immediately to the reset values with no pending IRQ.
- Latency:
  - Overflow edge to ST=1 is the same edge.
  - IRQ is visible in the cycle after that edge (it is combinational from ST).

Test Plan:
- Reset then reads: assert reset=0 mid-count, release -> TH/TL/TCON/PSC read 0 and IRQ=0. Read at BASE+16 -> hit=0, rdata=0.
- Basic overflow: TH=FFFF_FFFC, TL=FFFF_FFFE, PSC=0, TCON=3, kernel=0 -> TL reads FFFF_FFFF after 1 cycle and FFFF_FFFC after 2; ST=1 and IRQ=1 from the cycle after the overflow edge.
- Kernel masking and clear: with ST=1, drive kernel=1 -> IRQ=0 the same cycle. Write TCON=3 -> ST=0. Drive kernel=0 -> IRQ stays 0.
- Prescaler: PSC=3, TL=0, TCON=1 -> TL=1 after 4 cycles and 2 after 8. Clear EN at cycle 6, re-enable at cycle 10 -> TL=2 at cycle 12 (two remaining pcnt steps).
- IE off: TCON=1 across an overflow -> TL reloads TH, ST stays 0, IRQ stays 0.
- Collision: write TL=5 in the same cycle as a tick with TL=9 -> TL=5. Write TH=7 on the overflow edge with old TH=2 -> TL=2, TH=7.
